multi_lane_data_controller: RTL and testbench
=============================================

# multi_lane_data_controller

Parametrised successor to the lane data controller. It accepts a 64-bit AXI-Stream frame source with backpressure and `keep`, and buffers words in an internal FIFO. On each transmit slot it stripes the words across 1..LANES active lanes as per-lane block types: IDLE, DATA, SEP (end of frame with byte count) and CC (clock compensation). It sits between the user AXI interface and the per-lane scrambler/gearbox. Slot rate is set by `tx_en`, so one clock serves every lane-count mode.

## Interface
- `DATA_W`, 64, lane word width; multiple of 8.
- `LANES`, 4, maximum lane count; ≥1.
- `FIFO_DEPTH`, 8, input buffer depth in words; power of 2, ≥2.
- `CC_PERIOD`, 1000, `tx_en` slots between CC sequence starts; must exceed `CC_LEN`.
- `CC_LEN`, 3, consecutive CC columns per sequence.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `active_lanes`  in  $clog2(LANES+1)  requested lane count; 0 or >LANES is treated as 1.
- `tx_en`  in  1  transmit-slot strobe; one column is issued per high cycle.
- `s_axi_valid`  in  1  input word valid.
- `s_axi_ready`  out  1  input word accepted when valid && ready.
- `s_axi_last`  in  1  last word of frame.
- `s_axi_keep`  in  DATA_W/8  byte enables, contiguous from LSB; only meaningful with last.
- `s_axi_data`  in  DATA_W  word payload.
- `lane_type`  out  2*LANES  per lane: 0 IDLE, 1 DATA, 2 SEP, 3 CC; lane i at [2i+1:2i].
- `lane_data`  out  DATA_W*LANES  per-lane payload; lane i at [DATA_W*(i+1)-1:DATA_W*i].
- `col_valid`  out  1  one-cycle pulse when a new column is on the lane outputs.

## Operation
- **FIFO.** Each entry holds {data, last, keep}. A push is a valid&&ready handshake. `s_axi_ready` is registered: it is high when the next-cycle occupancy is below FIFO_DEPTH.
- **Lane count latch.** `active_lanes` is latched into `lanes_q` only in state IDLE. A change mid-frame takes effect after the frame's SEP has been issued.
- **States:** IDLE (no frame open), FRAME (frame open), PEND_SEP (full last word sent; SEP still owed), CC.
- **Column build** on `tx_en`, lanes 0..lanes_q-1 in order. Each lane pops one FIFO word if one is available:
  - Word without last → DATA with the word.
  - Last word with keep all ones → DATA. The next lane in the same column gets SEP with count 0. If no lane is left in the column, go to PEND_SEP and lane 0 of the next column gets SEP with count 0.
  - Last word with a partial keep, or keep 0 → SEP. lane_data[7:0] = popcount(keep); the valid bytes go in lane_data[8*popcount+7:8], and the rest is zero.
  - After a SEP, the remaining lanes in the column are IDLE. At most one frame ends per column.
  - FIFO empty → that lane and all later lanes in the column are IDLE. This is legal inside a frame.
- **Lane outputs.** Inactive lanes (index ≥ lanes_q) are always IDLE with data 0. Every IDLE and CC lane has lane_data 0.
- **State transitions:**
  - IDLE→FRAME on the first DATA.
  - FRAME→IDLE on SEP.
  - FRAME→PEND_SEP as described above; PEND_SEP→IDLE when the SEP is issued.
- **Clock compensation.** `cc_cnt` counts `tx_en` slots and wraps at CC_PERIOD-1. At the wrap, the next CC_LEN `tx_en` columns are CC on all active lanes, in any state.
  - No FIFO pops occur during CC.
  - The underlying state is preserved; a pending SEP is issued after the CC columns.
  - `cc_cnt` keeps counting during CC.

## Timing
- **Reset values:** `s_axi_ready` 0, `lane_type` all IDLE, `lane_data` 0, `col_valid` 0. The FIFO is flushed, `cc_cnt` is 0, the state is IDLE, and `lanes_q` is 1.
- **After reset:** `s_axi_ready` goes to 1 on the first rising edge after `rst_n` deasserts.
- **Reset mid-operation:** all outputs return to their reset values immediately (asynchronous). Buffered words are lost.
- **Latency:**
  - A word pushed at edge t can be popped by `tx_en` sampled at edge t+1 or later.
  - A column issued on `tx_en` at edge t appears on the lane outputs after edge t, with `col_valid` high for that cycle.
  - The lane outputs hold until the next column.
- **Full FIFO:** when the FIFO is full with no pop, `s_axi_ready` is low. A pop at edge t raises `s_axi_ready` after edge t.
- **Simultaneous push and pop** in the same edge leaves occupancy unchanged.
- **Pop count:** at most lanes_q words per column.
- **No `tx_en`:** nothing is popped and the state is unchanged.

## Test plan
- **1 lane, full-keep single-word frame.** active_lanes=1, tx_en=1 each cycle; one word 64'hDEADB00DDEADB00D, keep 8'hFF, last → column 1: lane0 DATA 64'hDEADB00DDEADB00D; column 2: SEP with lane_data 0; then IDLE.
- **2 lanes, partial keep on the last word.** active_lanes=2; three words w0,w1,w2, with w2 last and keep 8'h0F → column 1: DATA w0 on lane0, DATA w1 on lane1. Column 2: lane0 SEP, lane_data = {24'h0, w2[31:0], 8'd4}; lane1 IDLE. Lanes 2–3 stay IDLE throughout.
- **Backpressure.** tx_en=0, push 9 words → `s_axi_ready` drops after the 8th accept and the 9th is held. One tx_en with active_lanes=4 → 4 words popped in order, `s_axi_ready` high next cycle, the 9th word then accepted.
- **Clock compensation.** CC_PERIOD=16, CC_LEN=3, continuous 40-word frame on 2 lanes → after 16 slots, 3 columns of CC on lanes 0–1. No word is lost or reordered; data resumes with the next FIFO word.
- **Lane-count change mid-frame.** active_lanes changes 1→4 during a 5-word frame → DATA only on lane0 through the SEP; the next frame stripes over 4 lanes.
- **Reset mid-frame.** Assert rst_n=0 mid-frame → all lanes IDLE/0, `s_axi_ready`=0 immediately. After release, a new 1-word frame is transmitted correctly with no leftover data.

Source files
------------

// File: rtl/multi_lane_data_controller.sv
// multi_lane_data_controller: buffers AXI-Stream words and stripes them across active lanes as IDLE/DATA/SEP/CC blocks
module multi_lane_data_controller #(
  parameter int DATA_W     = 64,
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CC_PERIOD  = 1000,
  parameter int CC_LEN     = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [$clog2(LANES+1)-1:0]   active_lanes,
  input  logic                         tx_en,
  input  logic                         s_axi_valid,
  output logic                         s_axi_ready,
  input  logic                         s_axi_last,
  input  logic [DATA_W/8-1:0]          s_axi_keep,
  input  logic [DATA_W-1:0]            s_axi_data,
  output logic [2*LANES-1:0]           lane_type,
  output logic [DATA_W*LANES-1:0]      lane_data,
  output logic                         col_valid
);
  localparam int KW = DATA_W / 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int LW = $clog2(LANES + 1);
  localparam int PW = $clog2(CC_PERIOD);
  localparam int RW = $clog2(CC_LEN + 1);
  localparam logic [1:0] T_IDLE = 2'd0, T_DATA = 2'd1, T_SEP = 2'd2, T_CC = 2'd3;
  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_PEND} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic              mem_last [FIFO_DEPTH];
  logic [KW-1:0]     mem_keep [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, idx;
  logic [CW-1:0] count, cnt_n, pops, pop_n;
  logic [LW-1:0] lanes_q, eff_lanes;
  logic [PW-1:0] cc_cnt;
  logic [RW-1:0] cc_rem;
  logic [2*LANES-1:0] col_type;
  logic [DATA_W*LANES-1:0] col_data;
  logic [DATA_W-1:0] mask, masked;
  logic [7:0] pc;
  logic push, cc_on, cc_wrap, owed, ended, seen, stop;
  assign push = s_axi_valid && s_axi_ready;
  assign cc_on = cc_rem != '0;
  assign cc_wrap = cc_cnt == PW'(CC_PERIOD - 1);
  assign eff_lanes = (active_lanes == '0 || int'(active_lanes) > LANES) ? LW'(1) : active_lanes;
  // FIFO storage; entries are only meaningful between rd_ptr and wr_ptr, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= s_axi_data;
      mem_last[wr_ptr] <= s_axi_last;
      mem_keep[wr_ptr] <= s_axi_keep;
    end
  end
  // Build the next column lane by lane, popping FIFO words in order and deciding the frame state
  always_comb begin
    col_type = '0;
    col_data = '0;
    pops = '0;
    idx = rd_ptr;
    mask = '0;
    masked = '0;
    pc = '0;
    owed = state == S_PEND;
    ended = 1'b0;
    seen = 1'b0;
    stop = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      idx = rd_ptr + pops[AW-1:0];
      for (int b = 0; b < KW; b++) mask[8*b +: 8] = {8{mem_keep[idx][b]}};
      masked = mem_data[idx] & mask;
      pc = 8'($countones(mem_keep[idx]));
      if (i < int'(lanes_q) && !stop) begin
        if (cc_on) col_type[2*i +: 2] = T_CC;
        else if (owed) begin
          col_type[2*i +: 2] = T_SEP;
          owed = 1'b0;
          ended = 1'b1;
          stop = 1'b1;
        end else if (pops < count) begin
          pops = pops + 1'b1;
          if (!mem_last[idx] || &mem_keep[idx]) begin
            col_type[2*i +: 2] = T_DATA;
            col_data[DATA_W*i +: DATA_W] = mem_data[idx];
            seen = 1'b1;
            owed = mem_last[idx];
          end else begin
            col_type[2*i +: 2] = T_SEP;
            col_data[DATA_W*i +: DATA_W] = {masked[DATA_W-9:0], pc};
            ended = 1'b1;
            stop = 1'b1;
          end
        end else stop = 1'b1;
      end
    end
    state_n = (!tx_en || cc_on) ? state : ended ? S_IDLE : owed ? S_PEND : seen ? S_FRAME : state;
    pop_n = tx_en ? pops : '0;
    cnt_n = count + CW'(push) - pop_n;
  end
  // Pointers, occupancy, frame state, lane latch, CC scheduling and registered lane outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      lanes_q <= LW'(1);
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      s_axi_ready <= 1'b0;
      cc_cnt <= '0;
      cc_rem <= '0;
      lane_type <= '0;
      lane_data <= '0;
      col_valid <= 1'b0;
    end else begin
      state <= state_n;
      count <= cnt_n;
      s_axi_ready <= cnt_n < CW'(FIFO_DEPTH);
      rd_ptr <= rd_ptr + pop_n[AW-1:0];
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      lanes_q <= state_n == S_IDLE ? eff_lanes : lanes_q;
      col_valid <= tx_en;
      if (tx_en) begin
        cc_cnt <= cc_wrap ? '0 : cc_cnt + 1'b1;
        cc_rem <= cc_wrap ? RW'(CC_LEN) : cc_on ? cc_rem - 1'b1 : '0;
        lane_type <= col_type;
        lane_data <= col_data;
      end
    end
  end
endmodule

// File: tb/tb_multi_lane_data_controller.sv
// tb_multi_lane_data_controller: directed self-checking bench for the lane striping controller
module tb_multi_lane_data_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [2:0] active_lanes = 3'd1;
  logic tx_en = 1'b0;
  logic s_axi_valid = 1'b0;
  logic s_axi_ready;
  logic s_axi_last = 1'b0;
  logic [7:0] s_axi_keep = 8'hFF;
  logic [63:0] s_axi_data = '0;
  logic [7:0] lane_type;
  logic [255:0] lane_data;
  logic col_valid;
  int checks = 0;
  int failures = 0;
  int nx, rx, s;
  bit done, acc;
  logic [1:0] t;

  multi_lane_data_controller #(
    .DATA_W(64), .LANES(4), .FIFO_DEPTH(8), .CC_PERIOD(16), .CC_LEN(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .active_lanes(active_lanes), .tx_en(tx_en),
    .s_axi_valid(s_axi_valid), .s_axi_ready(s_axi_ready), .s_axi_last(s_axi_last),
    .s_axi_keep(s_axi_keep), .s_axi_data(s_axi_data), .lane_type(lane_type),
    .lane_data(lane_data), .col_valid(col_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] w(input int k);
    return 64'hA5C3_0000_0000_0000 + 64'(k);
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [2:0] al);
    rst_n = 1'b0;
    tx_en = 1'b0;
    s_axi_valid = 1'b0;
    s_axi_last = 1'b0;
    s_axi_keep = 8'hFF;
    active_lanes = al;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push(input logic [63:0] d, input logic l, input logic [7:0] k);
    s_axi_valid = 1'b1;
    s_axi_data = d;
    s_axi_last = l;
    s_axi_keep = k;
    tick();
    s_axi_valid = 1'b0;
    s_axi_last = 1'b0;
  endtask

  task automatic col_chk(input string tag, input logic [7:0] et, input logic [255:0] ed);
    tx_en = 1'b1;
    tick();
    tx_en = 1'b0;
    chk({tag, ".valid"}, 256'(col_valid), 256'(1'b1));
    chk({tag, ".type"}, 256'(lane_type), 256'(et));
    chk({tag, ".data"}, lane_data, ed);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("reset.ready", 256'(s_axi_ready), 256'(1'b0));
    chk("reset.type", 256'(lane_type), 256'(0));
    chk("reset.data", lane_data, 256'(0));
    chk("reset.col_valid", 256'(col_valid), 256'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("reset.ready_after", 256'(s_axi_ready), 256'(1'b1));

    do_reset(3'd1);
    push(64'hDEADB00DDEADB00D, 1'b1, 8'hFF);
    col_chk("one.c1", 8'h01, {192'h0, 64'hDEADB00DDEADB00D});
    col_chk("one.c2", 8'h02, 256'h0);
    tick();
    chk("one.hold_valid", 256'(col_valid), 256'(1'b0));
    chk("one.hold_type", 256'(lane_type), 256'(8'h02));
    col_chk("one.c3", 8'h00, 256'h0);

    do_reset(3'd2);
    push(64'h1111_2222_3333_4444, 1'b0, 8'hFF);
    push(64'h5555_6666_7777_8888, 1'b0, 8'hFF);
    push(64'h99AA_BBCC_DDEE_FF00, 1'b1, 8'h0F);
    col_chk("two.c1", 8'h05, {128'h0, 64'h5555_6666_7777_8888, 64'h1111_2222_3333_4444});
    col_chk("two.c2", 8'h02, {192'h0, 64'h0000_00DD_EEFF_0004});
    col_chk("two.c3", 8'h00, 256'h0);

    do_reset(3'd4);
    s_axi_valid = 1'b1;
    s_axi_keep = 8'hFF;
    s_axi_last = 1'b0;
    for (int k = 0; k < 7; k++) begin
      s_axi_data = w(k);
      tick();
    end
    chk("bp.ready7", 256'(s_axi_ready), 256'(1'b1));
    s_axi_data = w(7);
    tick();
    chk("bp.ready8", 256'(s_axi_ready), 256'(1'b0));
    s_axi_data = w(8);
    s_axi_last = 1'b1;
    tick();
    chk("bp.hold9", 256'(s_axi_ready), 256'(1'b0));
    tx_en = 1'b1;
    tick();
    tx_en = 1'b0;
    chk("bp.c1.type", 256'(lane_type), 256'(8'h55));
    chk("bp.c1.data", lane_data, {w(3), w(2), w(1), w(0)});
    chk("bp.ready_pop", 256'(s_axi_ready), 256'(1'b1));
    tick();
    s_axi_valid = 1'b0;
    s_axi_last = 1'b0;
    col_chk("bp.c2", 8'h55, {w(7), w(6), w(5), w(4)});
    col_chk("bp.c3", 8'h09, {192'h0, w(8)});

    do_reset(3'd2);
    for (int k = 0; k < 8; k++) push(w(k), 1'b0, 8'hFF);
    nx = 8;
    rx = 0;
    s = 0;
    done = 1'b0;
    s_axi_keep = 8'hFF;
    tx_en = 1'b1;
    while (!done && s < 120) begin
      s_axi_valid = nx < 40;
      s_axi_data = w(nx);
      s_axi_last = nx == 39;
      acc = s_axi_valid && s_axi_ready;
      tick();
      if (acc) nx++;
      chk($sformatf("cc.s%0d.upper", s), 256'(lane_type[7:4]), 256'(0));
      if (s >= 16 && s % 16 < 3) begin
        chk($sformatf("cc.s%0d.type", s), 256'(lane_type), 256'(8'h0F));
        chk($sformatf("cc.s%0d.data", s), lane_data, 256'h0);
      end else begin
        for (int l = 0; l < 2; l++) begin
          t = lane_type[2*l +: 2];
          if (t == 2'd1) begin
            chk($sformatf("cc.s%0d.l%0d.word", s, l), 256'(lane_data[64*l +: 64]), 256'(w(rx)));
            rx++;
          end else if (t == 2'd2) begin
            chk($sformatf("cc.s%0d.l%0d.sep", s, l), 256'(lane_data[64*l +: 64]), 256'h0);
            chk("cc.word_count", 256'(rx), 256'(40));
            done = 1'b1;
          end else if (t == 2'd3) chk($sformatf("cc.s%0d.l%0d.stray_cc", s, l), 256'(t), 256'(0));
        end
      end
      s++;
    end
    tx_en = 1'b0;
    s_axi_valid = 1'b0;
    s_axi_last = 1'b0;
    chk("cc.frame_done", 256'(done), 256'(1'b1));

    do_reset(3'd1);
    for (int k = 0; k < 5; k++) push(w(20 + k), k == 4, 8'hFF);
    col_chk("lc.c0", 8'h01, {192'h0, w(20)});
    active_lanes = 3'd4;
    for (int k = 1; k < 5; k++) col_chk($sformatf("lc.c%0d", k), 8'h01, {192'h0, w(20 + k)});
    col_chk("lc.sep", 8'h02, 256'h0);
    for (int k = 0; k < 4; k++) push(w(30 + k), k == 3, 8'hFF);
    col_chk("lc.wide", 8'h55, {w(33), w(32), w(31), w(30)});
    col_chk("lc.sep2", 8'h02, 256'h0);

    do_reset(3'd2);
    for (int k = 0; k < 3; k++) push(w(40 + k), 1'b0, 8'hFF);
    col_chk("rst.pre", 8'h05, {128'h0, w(41), w(40)});
    #3 rst_n = 1'b0;
    #1;
    chk("rst.ready", 256'(s_axi_ready), 256'(1'b0));
    chk("rst.type", 256'(lane_type), 256'(0));
    chk("rst.data", lane_data, 256'h0);
    chk("rst.col_valid", 256'(col_valid), 256'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst.ready_after", 256'(s_axi_ready), 256'(1'b1));
    push(64'h0123_4567_89AB_CDEF, 1'b1, 8'h03);
    col_chk("rst.post", 8'h02, {192'h0, 64'h0000_0000_00CD_EF02});
    col_chk("rst.idle", 8'h00, 256'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
